// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and reset divisor for the pipeline clock-step controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } step_state_t;

  localparam int unsigned DEFAULT_LIMIT = 2500000;

  function automatic logic is_active(step_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// Control/status bundle between the debug host side and the clock-step controller.
interface clock_step_controller_if #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
);
  logic              div_load;
  logic [CNT_W-1:0]  div_value;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic [STEP_W-1:0] step_num;
  logic              bkpt_hit;
  logic              cpu_ce;
  logic [1:0]        state;
  logic [STEP_W-1:0] steps_left;
  logic [31:0]       ce_count;

  modport master (
    output div_load, div_value, run_req, halt_req, step_req, step_num, bkpt_hit,
    input  cpu_ce, state, steps_left, ce_count
  );

  modport slave (
    input  div_load, div_value, run_req, halt_req, step_req, step_num, bkpt_hit,
    output cpu_ce, state, steps_left, ce_count
  );
endinterface

// File: rtl/ce_prescaler.sv
// Programmable prescaler: counts 0..div-1 and flags the terminal count as a tick.
module ce_prescaler #(
  parameter int          CNT_W     = 32,
  parameter int unsigned RESET_DIV = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_INIT = (RESET_DIV == 0) ? CNT_W'(1) : CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == div_q - CNT_W'(1));
  // A load restarts the period, so a terminal count in the same cycle is discarded.
  assign tick = wrap && !hold && !load;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_INIT;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= (load_value == '0) ? CNT_W'(1) : load_value;
      cnt_q <= '0;
    end else if (hold || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// Run/halt/single-step sequencer producing a one-cycle clock enable for the pipeline.
// state | meaning
// HALT  | idle, no enables, waiting for run or step
// RUN   | free-running enables every div cycles
// STEP  | issuing steps_left enables, then back to HALT
// BREAK | stopped by breakpoint, steps_left preserved
module clock_step_controller
  import clk_ctrl_pkg::*;
#(
  parameter int          CNT_W         = 32,
  parameter int          STEP_W        = 16,
  parameter int unsigned DEFAULT_LIMIT = clk_ctrl_pkg::DEFAULT_LIMIT
) (
  input logic                    clk,
  input logic                    reset,
  clock_step_controller_if.slave bus
);

  step_state_t       state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              tick;
  logic              hold;
  logic              cpu_ce_q;
  logic [31:0]       ce_count_q;

  // Any stop request also clears the prescaler so HALT/BREAK always start from cnt=0.
  assign hold = !is_active(state_q) || bus.halt_req || bus.bkpt_hit;

  ce_prescaler #(
    .CNT_W     (CNT_W),
    .RESET_DIV (DEFAULT_LIMIT)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .load       (bus.div_load),
    .load_value (bus.div_value),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
          steps_d = '0;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
          steps_d = '0;
        end else if (bus.step_req && (bus.step_num != '0)) begin
          state_d = ST_STEP;
          steps_d = bus.step_num;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.bkpt_hit) begin
          state_d = ST_BREAK;
        end
      end
      ST_STEP: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
          steps_d = '0;
        end else if (bus.bkpt_hit) begin
          state_d = ST_BREAK;
        end else if (tick) begin
          if (steps_q == STEP_W'(1)) begin
            state_d = ST_HALT;
            steps_d = '0;
          end else begin
            steps_d = steps_q - STEP_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_HALT;
        steps_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HALT;
      steps_q    <= '0;
      cpu_ce_q   <= 1'b0;
      ce_count_q <= '0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      cpu_ce_q <= tick;
      if (tick) begin
        ce_count_q <= ce_count_q + 32'd1;
      end
    end
  end

  assign bus.cpu_ce     = cpu_ce_q;
  assign bus.state      = state_q;
  assign bus.steps_left = steps_q;
  assign bus.ce_count   = ce_count_q;

endmodule
